// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter: FSM states and default limits.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        D_BUSY  = 2'd2
    } arb_state_t;

    localparam int STARVE_MAX_DEF = 3;
    localparam int TIMEOUT_DEF    = 15;

    // Bits needed to hold 0..max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
// Latency: cnt/at_max update one cycle after inc/clr.
// Backpressure: none; an increment at MAX is dropped.
// Ports: clk, reset (sync, active-high), inc, clr -> cnt[WIDTH], at_max (cnt == MAX).
module sat_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt,
    output logic             at_max
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    assign at_max = (cnt == MAX_V);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store.
// Latency: request in cycle 0, m_en from cycle 1, ready in the same cycle as m_ack.
// Backpressure: requester is stalled (req=1, ready=0) until its access is acked.
// Ports: clk/reset; if_req/if_addr -> if_rdata/if_ready; d_read/d_write/d_addr/d_wdata
//        -> d_rdata/d_ready; m_en/m_we/m_addr/m_wdata <- m_rdata/m_ack; err (sticky timeout).
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          d_read,
    input  logic          d_write,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ack,
    output logic          err
);

    localparam int SW = cnt_width(STARVE_MAX);
    // to_cnt counts no-ack wait cycles; the abort fires on the wait cycle that
    // would bring it to TIMEOUT, so the counter itself only needs TIMEOUT-1.
    localparam int TW = cnt_width(TIMEOUT - 1);

    arb_state_t    state;
    logic [SW-1:0] starve_cnt;
    logic [TW-1:0] to_cnt;
    logic          starve_at_max;
    logic          to_at_max;

    logic d_req;
    logic busy;
    logic d_grant;
    logic if_grant;
    logic abort;

    assign d_req    = d_read | d_write;
    assign busy     = (state != IDLE);
    // Data side wins unless fetch is waiting and has been passed over STARVE_MAX times.
    assign d_grant  = !busy && d_req && (!if_req || !starve_at_max);
    assign if_grant = !busy && if_req && !d_grant;
    assign abort    = busy && !m_ack && to_at_max;

    // Ready is combinational off m_ack; suppressed while reset abandons the access.
    assign if_ready = !reset && (state == IF_BUSY) && m_ack;
    assign d_ready  = !reset && (state == D_BUSY) && m_ack;
    assign if_rdata = if_ready ? m_rdata : '0;
    assign d_rdata  = d_ready  ? m_rdata : '0;

    sat_counter #(
        .WIDTH (SW),
        .MAX   (STARVE_MAX)
    ) u_starve_cnt (
        .clk    (clk),
        .reset  (reset),
        .inc    (d_grant && if_req),
        .clr    (if_grant || (d_grant && !if_req)),
        .cnt    (starve_cnt),
        .at_max (starve_at_max)
    );

    sat_counter #(
        .WIDTH (TW),
        .MAX   (TIMEOUT - 1)
    ) u_to_cnt (
        .clk    (clk),
        .reset  (reset),
        .inc    (busy && !m_ack && !to_at_max),
        .clr    (!busy || m_ack),
        .cnt    (to_cnt),
        .at_max (to_at_max)
    );

    // Counter values are consumed only through at_max; kept as named nets for debug.
    logic unused_cnt_view;
    assign unused_cnt_view = ^{starve_cnt, to_cnt};

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            m_en    <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_grant) begin
                        state   <= D_BUSY;
                        m_en    <= 1'b1;
                        m_we    <= d_write;   // read+write together is a write
                        m_addr  <= d_addr;
                        m_wdata <= d_wdata;
                    end else if (if_grant) begin
                        state   <= IF_BUSY;
                        m_en    <= 1'b1;
                        m_we    <= 1'b0;
                        m_addr  <= if_addr;
                        m_wdata <= '0;
                    end
                end
                default: begin
                    // IF_BUSY, D_BUSY (and the unused encoding, which times out back to IDLE).
                    if (m_ack) begin
                        state <= IDLE;
                        m_en  <= 1'b0;
                        m_we  <= 1'b0;
                    end else if (abort) begin
                        state <= IDLE;
                        m_en  <= 1'b0;
                        m_we  <= 1'b0;
                        err   <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner sequences,
// and randomized traffic against a transaction-level reference model.
// Clock period 10; inputs change 1 after posedge; outputs sampled on negedge.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SM = 3;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ready;
    logic          m_en;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          m_ack;
    logic          err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .STARVE_MAX(SM), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack), .err(err)
    );

    typedef struct {
        logic        ifr, rd, wr;
        logic [31:0] ia, da, wd, rdat;
        int          lat;
        logic        e_we;
        logic [31:0] e_addr, e_wdata;
        logic        e_is_if;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_req = 0; if_addr = '0; d_read = 0; d_write = 0;
        d_addr = '0; d_wdata = '0; m_rdata = '0; m_ack = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        clear_inputs();
        next_cycle();
        reset = 0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        do_reset();
        if_req = v.ifr; if_addr = v.ia;
        d_read = v.rd; d_write = v.wr; d_addr = v.da; d_wdata = v.wd;
        m_rdata = v.rdat; m_ack = 0;
        @(negedge clk);
        chk($sformatf("v%0d_grant_cycle_m_en", idx), m_en, 0);
        next_cycle();
        for (int k = 0; k <= v.lat; k++) begin
            m_ack = (k == v.lat);
            @(negedge clk);
            chk($sformatf("v%0d_m_en", idx), m_en, 1);
            chk($sformatf("v%0d_m_addr", idx), m_addr, v.e_addr);
            chk($sformatf("v%0d_m_we", idx), m_we, v.e_we);
            if (!v.e_is_if) chk($sformatf("v%0d_m_wdata", idx), m_wdata, v.e_wdata);
            chk($sformatf("v%0d_if_ready", idx), if_ready, (k == v.lat) && v.e_is_if);
            chk($sformatf("v%0d_d_ready", idx), d_ready, (k == v.lat) && !v.e_is_if);
            if (k == v.lat) begin
                chk($sformatf("v%0d_if_rdata", idx), if_rdata, v.e_is_if ? v.rdat : 32'h0);
                chk($sformatf("v%0d_d_rdata", idx), d_rdata, v.e_is_if ? 32'h0 : v.rdat);
            end
            next_cycle();
        end
        clear_inputs();
        @(negedge clk);
        chk($sformatf("v%0d_m_en_drop", idx), m_en, 0);
        next_cycle();
    endtask

    task automatic starvation_seq();
        int exp_seq[5];
        int got;
        int waitc;
        exp_seq = '{1, 1, 1, 2, 1};   // 1 = data grant, 2 = fetch grant
        do_reset();
        if_req = 1; if_addr = 32'h40; d_read = 1; d_addr = 32'h100; m_ack = 0;
        for (int g = 0; g < 5; g++) begin
            waitc = 0;
            @(negedge clk);
            while (!m_en && waitc < 6) begin
                next_cycle();
                @(negedge clk);
                waitc++;
            end
            got = !m_en ? 0 : (m_addr == 32'h100) ? 1 : 2;
            chk($sformatf("starve_grant_%0d", g), got, exp_seq[g]);
            m_ack = 1;
            next_cycle();
            m_ack = 0;
        end
        clear_inputs();
    endtask

    task automatic timeout_seq();
        int  busy_cycles = 0;
        logic seen_ready = 0;
        logic fired = 0;
        do_reset();
        d_read = 1; d_addr = 32'h200; m_ack = 0;
        for (int c = 0; c < 40 && !fired; c++) begin
            @(negedge clk);
            if (d_ready || if_ready) seen_ready = 1;
            if (err) fired = 1;
            else begin
                if (m_en) busy_cycles++;
                next_cycle();
            end
        end
        chk("to_err_set", fired, 1);
        chk("to_busy_cycles", busy_cycles, TO);
        chk("to_m_en_dropped", m_en, 0);
        chk("to_no_ready", seen_ready, 0);
        next_cycle();
        @(negedge clk);
        chk("to_rearbitrated_m_en", m_en, 1);
        m_ack = 1;
        #1;
        chk("to_retry_d_ready", d_ready, 1);
        chk("to_err_sticky", err, 1);
        next_cycle();
        d_read = 0; m_ack = 0;
        @(negedge clk);
        chk("to_err_sticky_idle", err, 1);
        do_reset();
        @(negedge clk);
        chk("to_err_cleared_by_reset", err, 0);
        next_cycle();
    endtask

    task automatic reset_mid_seq();
        do_reset();
        d_read = 1; d_addr = 32'h300;
        next_cycle();
        @(negedge clk);
        chk("rstmid_busy", m_en, 1);
        next_cycle();
        reset = 1; d_read = 0; m_ack = 1;
        @(negedge clk);
        chk("rstmid_no_ready_in_reset", d_ready, 0);
        next_cycle();
        reset = 0;
        @(negedge clk);
        chk("rstmid_m_en", m_en, 0);
        chk("rstmid_m_addr", m_addr, 0);
        chk("rstmid_late_ack_d_ready", d_ready, 0);
        chk("rstmid_err", err, 0);
        next_cycle();
        @(negedge clk);
        chk("rstmid_late_ack2_d_ready", d_ready, 0);
        chk("rstmid_stays_idle", m_en, 0);
        m_ack = 0;
        next_cycle();
    endtask

    // Reference model: which requester owns the memory, what it asked for,
    // how many times fetch has been passed over, and how long we have waited.
    task automatic random_run(input int ncyc);
        int          owner = 0;     // 0 none, 1 fetch, 2 data
        int          passed = 0;
        int          waited = 0;
        int          stall = 0;
        int          op;
        logic        e_err = 0;
        logic        e_we = 0;
        logic [31:0] e_addr = 0;
        logic [31:0] e_wd = 0;
        logic        exp_ifr, exp_dr;
        logic        if_done = 0, d_done = 0;
        do_reset();
        for (int c = 0; c < ncyc; c++) begin
            if (if_done) if_req = 0;
            if (d_done) begin d_read = 0; d_write = 0; end
            if (stall > 0) begin
                m_ack = 0;
                stall--;
            end else begin
                m_ack = ($urandom_range(1, 0) == 1);
                if ($urandom_range(99, 0) == 0) stall = 20;
            end
            m_rdata = $urandom();
            if (!if_req && $urandom_range(2, 0) == 0) begin
                if_req = 1; if_addr = $urandom();
            end
            if (!d_read && !d_write && $urandom_range(2, 0) == 0) begin
                op = $urandom_range(2, 0);
                d_read = (op != 1); d_write = (op != 0);
                d_addr = $urandom(); d_wdata = $urandom();
            end

            @(negedge clk);
            exp_ifr = (owner == 1) && m_ack;
            exp_dr  = (owner == 2) && m_ack;
            chk("rnd_m_en", m_en, owner != 0);
            if (owner != 0) begin
                chk("rnd_m_addr", m_addr, e_addr);
                chk("rnd_m_we", m_we, e_we);
                if (owner == 2) chk("rnd_m_wdata", m_wdata, e_wd);
            end
            chk("rnd_if_ready", if_ready, exp_ifr);
            chk("rnd_d_ready", d_ready, exp_dr);
            chk("rnd_if_rdata", if_rdata, exp_ifr ? m_rdata : 32'h0);
            chk("rnd_d_rdata", d_rdata, exp_dr ? m_rdata : 32'h0);
            chk("rnd_err", err, e_err);

            if (owner == 0) begin
                waited = 0;
                if ((d_read || d_write) && (!if_req || passed < SM)) begin
                    owner = 2; e_we = d_write; e_addr = d_addr; e_wd = d_wdata;
                    passed = if_req ? ((passed < SM) ? passed + 1 : passed) : 0;
                end else if (if_req) begin
                    owner = 1; e_we = 0; e_addr = if_addr; passed = 0;
                end
            end else if (m_ack) begin
                owner = 0;
            end else begin
                waited++;
                if (waited == TO) begin
                    owner = 0;
                    e_err = 1;
                end
            end

            if_done = if_ready;
            d_done  = d_ready;
            next_cycle();
        end
        clear_inputs();
    endtask

    initial begin
        vecs[0] = '{ifr:1, rd:0, wr:0, ia:32'h40, da:32'h0, wd:32'h0, rdat:32'h8C020004, lat:0,
                    e_we:0, e_addr:32'h40, e_wdata:32'h0, e_is_if:1};
        vecs[1] = '{ifr:0, rd:1, wr:0, ia:32'h0, da:32'h100, wd:32'h0, rdat:32'h12345678, lat:2,
                    e_we:0, e_addr:32'h100, e_wdata:32'h0, e_is_if:0};
        vecs[2] = '{ifr:0, rd:0, wr:1, ia:32'h0, da:32'h20, wd:32'hDEADBEEF, rdat:32'h0, lat:3,
                    e_we:1, e_addr:32'h20, e_wdata:32'hDEADBEEF, e_is_if:0};
        vecs[3] = '{ifr:0, rd:1, wr:1, ia:32'h0, da:32'h24, wd:32'hCAFEF00D, rdat:32'h0, lat:1,
                    e_we:1, e_addr:32'h24, e_wdata:32'hCAFEF00D, e_is_if:0};
        vecs[4] = '{ifr:1, rd:1, wr:0, ia:32'h44, da:32'h100, wd:32'h0, rdat:32'hA5A5A5A5, lat:1,
                    e_we:0, e_addr:32'h100, e_wdata:32'h0, e_is_if:0};
        vecs[5] = '{ifr:0, rd:1, wr:0, ia:32'h0, da:32'h103, wd:32'h0, rdat:32'h0BADF00D, lat:0,
                    e_we:0, e_addr:32'h103, e_wdata:32'h0, e_is_if:0};
        vecs[6] = '{ifr:1, rd:0, wr:0, ia:32'hFFFFFFFF, da:32'h0, wd:32'h0, rdat:32'hFFFFFFFF, lat:4,
                    e_we:0, e_addr:32'hFFFFFFFF, e_wdata:32'h0, e_is_if:1};

        reset = 1;
        clear_inputs();
        @(negedge clk);
        chk("rst_m_en", m_en, 0);
        chk("rst_m_we", m_we, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_err", err, 0);
        chk("rst_if_ready", if_ready, 0);
        chk("rst_d_ready", d_ready, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        next_cycle();
        reset = 0;

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        starvation_seq();
        timeout_seq();
        reset_mid_seq();
        random_run(3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
